// File: rtl/srambank_pipe.sv
// Parametrised synchronous SRAM bank: NBANKS sub-banks of ROWS words, lane write
// masks, 1- or 2-cycle read latency with a read-valid strobe and a sticky collision flag.
module srambank_pipe #(
    parameter int unsigned ROWS    = 128,
    parameter int unsigned NBANKS  = 4,
    parameter int unsigned WIDTH   = 34,
    parameter int unsigned LANE_W  = 8,
    parameter int unsigned OUT_REG = 0,
    localparam int unsigned NLANES = (WIDTH + LANE_W - 1) / LANE_W,
    localparam int unsigned AW     = $clog2(ROWS * NBANKS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ADDRESS,
    input  logic [WIDTH-1:0]  wd,
    input  logic [NLANES-1:0] wmask,
    input  logic              banksel,
    input  logic              read,
    input  logic              write,
    output logic [WIDTH-1:0]  dataout,
    output logic              rvalid,
    output logic              rw_err
);

    localparam int unsigned RB = $clog2(ROWS);
    localparam int unsigned BB = $clog2(NBANKS);

    logic [RB-1:0]    row;
    logic [BB-1:0]    bank;
    logic             rd_en;
    logic             wr_en;
    logic [WIDTH-1:0] bitmask;

    assign row  = ADDRESS[RB-1:0];
    assign bank = ADDRESS[AW-1:RB];

    // Writes win a collision; nothing is accepted while reset is high.
    always_comb begin
        rd_en = banksel & read & ~write & ~reset;
        wr_en = banksel & write & ~reset;
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_mask
        assign bitmask[j] = wmask[j / LANE_W];
    end

    logic [NBANKS-1:0][WIDTH-1:0] bank_rd;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [WIDTH-1:0] mem [ROWS];
        logic [WIDTH-1:0] rd_q;
        logic             hit;

        assign hit = (bank == BB'(b));

        always_ff @(posedge clk) begin
            if (wr_en && hit) begin
                mem[row] <= (mem[row] & ~bitmask) | (wd & bitmask);
            end
        end

        // Per-bank read register holds its last word, so dataout holds between reads.
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_q <= '0;
            end else if (rd_en && hit) begin
                rd_q <= mem[row];
            end
        end

        assign bank_rd[b] = rd_q;
    end

    logic [BB-1:0]    bsel_q, bsel_d;
    logic             v1_q, v1_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rd_mux;

    always_comb begin
        bsel_d = bsel_q;
        v1_d   = rd_en;
        err_d  = err_q | (banksel & read & write);
        if (rd_en) begin
            bsel_d = bank;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bsel_q <= '0;
            v1_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            bsel_q <= bsel_d;
            v1_q   <= v1_d;
            err_q  <= err_d;
        end
    end

    assign rd_mux = bank_rd[bsel_q];
    assign rw_err = err_q;

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] dout_q, dout_d;
        logic             v2_q;

        always_comb begin
            dout_d = dout_q;
            if (v1_q) begin
                dout_d = rd_mux;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q <= '0;
                v2_q   <= 1'b0;
            end else begin
                dout_q <= dout_d;
                v2_q   <= v1_q;
            end
        end

        assign dataout = dout_q;
        assign rvalid  = v2_q;
    end else begin : g_noreg
        assign dataout = rd_mux;
        assign rvalid  = v1_q;
    end

endmodule

// File: tb/tb_srambank_pipe.sv
// Bench for srambank_pipe: drives two configurations (34/8 latency 1, 64/16 latency 2)
// from one directed sequence; read results are scoreboarded with their due cycle.
module tb_srambank_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [8:0]  addr;
    logic [63:0] wd;
    logic [4:0]  wm0;
    logic [3:0]  wm1;
    logic        banksel, read, write;

    logic [33:0] dout0;
    logic [63:0] dout1;
    logic        rv0, rv1, err0, err1;

    srambank_pipe #(.ROWS(128), .NBANKS(4), .WIDTH(34), .LANE_W(8), .OUT_REG(0)) dut0 (
        .clk(clk), .reset(reset), .ADDRESS(addr), .wd(wd[33:0]), .wmask(wm0),
        .banksel(banksel), .read(read), .write(write),
        .dataout(dout0), .rvalid(rv0), .rw_err(err0)
    );

    srambank_pipe #(.ROWS(128), .NBANKS(4), .WIDTH(64), .LANE_W(16), .OUT_REG(1)) dut1 (
        .clk(clk), .reset(reset), .ADDRESS(addr), .wd(wd), .wmask(wm1),
        .banksel(banksel), .read(read), .write(write),
        .dataout(dout1), .rvalid(rv1), .rw_err(err1)
    );

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0, e1;
    logic [33:0] m0[int];
    logic [63:0] m1[int];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rv0 === 1'b1) begin
            tests++;
            assert (q0.size() > 0) else begin
                fails++;
                $error("FAIL rvalid0_unexpected: observed 1 expected 0 at cycle %0d", cyc);
            end
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                check("dout0_data", {30'b0, dout0}, e0.data);
                check("dout0_latency", 64'(cyc), 64'(e0.due));
            end
        end
        if (rv1 === 1'b1) begin
            tests++;
            assert (q1.size() > 0) else begin
                fails++;
                $error("FAIL rvalid1_unexpected: observed 1 expected 0 at cycle %0d", cyc);
            end
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                check("dout1_data", dout1, e1.data);
                check("dout1_latency", 64'(cyc), 64'(e1.due));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            banksel = 1'b0; read = 1'b0; write = 1'b0;
        end
    endtask

    task automatic model_write(input logic [8:0] a, input logic [63:0] d,
                               input logic [4:0] w0, input logic [3:0] w1);
        if (!m0.exists(int'(a))) m0[int'(a)] = 'x;
        if (!m1.exists(int'(a))) m1[int'(a)] = 'x;
        for (int j = 0; j < 34; j++) if (w0[j / 8]) m0[int'(a)][j] = d[j];
        for (int j = 0; j < 64; j++) if (w1[j / 16]) m1[int'(a)][j] = d[j];
    endtask

    task automatic wr(input logic [8:0] a, input logic [63:0] d,
                      input logic [4:0] w0, input logic [3:0] w1);
        @(negedge clk);
        addr = a; wd = d; wm0 = w0; wm1 = w1;
        banksel = 1'b1; read = 1'b0; write = 1'b1;
        model_write(a, d, w0, w1);
    endtask

    task automatic collide(input logic [8:0] a, input logic [63:0] d);
        @(negedge clk);
        addr = a; wd = d; wm0 = '1; wm1 = '1;
        banksel = 1'b1; read = 1'b1; write = 1'b1;
        model_write(a, d, 5'h1F, 4'hF);
    endtask

    task automatic rd(input logic [8:0] a, input bit expect1);
        @(negedge clk);
        addr = a; banksel = 1'b1; read = 1'b1; write = 1'b0;
        q0.push_back('{data: {30'b0, m0[int'(a)]}, due: cyc + 1});
        if (expect1) q1.push_back('{data: m1[int'(a)], due: cyc + 2});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; addr = '0; wd = '0; wm0 = '0; wm1 = '0;
        banksel = 1'b0; read = 1'b0; write = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_dout0", {30'b0, dout0}, 64'h0);
        check("reset_dout1", dout1, 64'h0);
        check("reset_rvalid", {62'b0, rv0, rv1}, 64'h0);
        check("reset_rw_err", {62'b0, err0, err1}, 64'h0);
        reset = 1'b0;

        // Basic write then read
        wr(9'h005, 64'hCAFE_0003_DEAD_BEEF, 5'h1F, 4'hF);
        rd(9'h005, 1'b1);
        idle(4);
        check("t1_dout0", {30'b0, dout0}, 64'h3_DEAD_BEEF);
        check("t1_dout1", dout1, 64'hCAFE_0003_DEAD_BEEF);

        // Lane-masked write
        wr(9'h010, 64'h0, 5'h1F, 4'hF);
        wr(9'h010, 64'hFFFF_FFFF_FFFF_FFFF, 5'b00101, 4'b0101);
        rd(9'h010, 1'b1);
        idle(4);
        check("t2_dout0", {30'b0, dout0}, 64'h0_00FF_00FF);
        check("t2_dout1", dout1, 64'h0000_FFFF_0000_FFFF);

        // Sub-bank edges and back-to-back reads
        wr(9'h07F, 64'h1, 5'h1F, 4'hF);
        wr(9'h080, 64'h2, 5'h1F, 4'hF);
        wr(9'h1FF, 64'h3, 5'h1F, 4'hF);
        rd(9'h07F, 1'b1);
        rd(9'h080, 1'b1);
        rd(9'h1FF, 1'b1);
        idle(4);
        check("t3_dout0_last", {30'b0, dout0}, 64'h3);

        // Collision: write wins, read dropped, sticky error
        collide(9'h005, 64'h7);
        idle(1);
        check("t4_rw_err_set", {62'b0, err0, err1}, 64'h3);
        idle(4);
        check("t4_rw_err_sticky", {62'b0, err0, err1}, 64'h3);
        rd(9'h005, 1'b1);
        idle(4);
        check("t4_readback0", {30'b0, dout0}, 64'h7);

        // Read, then write same word, then deselected traffic: dataout holds
        rd(9'h005, 1'b1);
        wr(9'h005, 64'h55, 5'h1F, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addr = 9'h005; wd = 64'hFFFF; banksel = 1'b0; read = 1'b1; write = 1'b1;
        end
        check("t6_hold_dout0", {30'b0, dout0}, 64'h7);
        check("t6_hold_dout1", dout1, 64'h7);
        rd(9'h005, 1'b1);
        idle(4);
        check("t6_new_dout1", dout1, 64'h55);

        // Reset right after a read issue; write during reset is ignored
        rd(9'h005, 1'b0);
        @(negedge clk);
        reset = 1'b1; addr = 9'h005; wd = 64'h1234; wm0 = '1; wm1 = '1;
        banksel = 1'b1; read = 1'b0; write = 1'b1;
        @(negedge clk);
        banksel = 1'b0; write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("t5_dout0", {30'b0, dout0}, 64'h0);
        check("t5_dout1", dout1, 64'h0);
        check("t5_rw_err", {62'b0, err0, err1}, 64'h0);
        idle(3);
        check("t5_rvalid", {62'b0, rv0, rv1}, 64'h0);
        rd(9'h005, 1'b1);
        idle(5);
        check("t5_reset_write_ignored", dout1, 64'h55);

        check("q0_drained", 64'(q0.size()), 64'h0);
        check("q1_drained", 64'(q1.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
